// File: rtl/psram_dma_pkg.sv
// Shared definitions for the PSRAM DMA CSR block: register map, CTRL field positions,
// task-command encodings and the command-slot state type.
package psram_dma_pkg;

  localparam int unsigned REG_CTRL       = 0;
  localparam int unsigned REG_IRQ_EN     = 1;
  localparam int unsigned REG_IRQ_STATUS = 2;
  localparam int unsigned REG_IRQ_PEND   = 3;
  localparam int unsigned REG_CH_BASE    = 4;

  localparam int unsigned CTRL_ERR_BIT  = 23;
  localparam int unsigned CTRL_TMAX_LSB = 20;
  localparam int unsigned CTRL_EN_BIT   = 19;
  localparam int unsigned CTRL_OP_LSB   = 16;
  localparam int unsigned CTRL_VAL_LSB  = 8;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_ADD    = 2'd2,
    OP_REMOVE = 2'd3
  } cmd_op_e;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_PEND = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/psram_dma_ch_csr.sv
// One DMA channel's registers: table base, trigger mask, sticky IRQ status bit and,
// with PSRAM_CSR_IRQ_CNT_EN defined, a saturating clear-on-read event counter.
module psram_dma_ch_csr
  import psram_dma_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int TRIG_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tbl_we_i,
  input  logic              trig_we_i,
  input  logic [3:0]        bsel_i,
  input  logic [31:0]       wdata_i,
  input  logic              st_clr_i,
  input  logic              irq_set_i,
`ifdef PSRAM_CSR_IRQ_CNT_EN
  input  logic              cnt_rd_i,
  output logic [7:0]        cnt_o,
`endif
  output logic [ADDR_W-1:0] tbl_o,
  output logic [TRIG_W-1:0] trig_o,
  output logic              status_o
);

  logic [ADDR_W-1:0] tbl_q, tbl_d;
  logic [TRIG_W-1:0] trig_q, trig_d;
  logic              status_q, status_d;

  always_comb begin
    tbl_d    = tbl_q;
    trig_d   = trig_q;
    status_d = status_q;
    if (tbl_we_i) begin
      for (int b = 0; b < ADDR_W; b++) begin
        if (bsel_i[b/8]) tbl_d[b] = wdata_i[b];
      end
    end
    if (trig_we_i) begin
      for (int b = 0; b < TRIG_W; b++) begin
        if (bsel_i[b/8]) trig_d[b] = wdata_i[b];
      end
    end
    // A done pulse landing on the clearing write must not be lost.
    if (st_clr_i)  status_d = 1'b0;
    if (irq_set_i) status_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tbl_q    <= '0;
      trig_q   <= '0;
      status_q <= 1'b0;
    end else begin
      tbl_q    <= tbl_d;
      trig_q   <= trig_d;
      status_q <= status_d;
    end
  end

  assign tbl_o    = tbl_q;
  assign trig_o   = trig_q;
  assign status_o = status_q;

`ifdef PSRAM_CSR_IRQ_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_rd_i)                          cnt_d = {7'd0, irq_set_i};
    else if (irq_set_i && cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/psram_dma_csr.sv
// AHB-slave CSR block for the multi-channel PSRAM DMA engine: CTRL/command slot, IRQ
// registers and per-channel table/trigger registers. Optional counters: PSRAM_CSR_IRQ_CNT_EN.
module psram_dma_csr
  import psram_dma_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 17,
  parameter int TRIG_W = 32,
  parameter int BA_W   = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ahb_bus_sel,
  input  logic                     ahb_bus_wr,
  input  logic                     ahb_bus_rd,
  input  logic [BA_W-1:0]          ahb_bus_addr,
  input  logic [3:0]               ahb_bus_bsel,
  input  logic [31:0]              ahb_bus_wdata,
  output logic [31:0]              ahb_bus_rdata,
  output logic                     dma_en,
  output logic [2:0]               task_max,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_op,
  output logic [7:0]               cmd_val,
  input  logic                     cmd_ready,
  input  logic [7:0]               task_list,
  output logic [CH_NUM*ADDR_W-1:0] table_addr,
  output logic [CH_NUM*TRIG_W-1:0] trig_mask,
  input  logic [CH_NUM-1:0]        irq_set,
  output logic                     irq
);

  logic wen, ren, ctrl_wr, op_wr;

  assign wen     = ahb_bus_sel & ahb_bus_wr;
  assign ren     = ahb_bus_sel & ahb_bus_rd;
  assign ctrl_wr = wen && (ahb_bus_addr == BA_W'(REG_CTRL));
  assign op_wr   = ctrl_wr && ahb_bus_bsel[2] &&
                   (ahb_bus_wdata[CTRL_OP_LSB +: 2] != 2'b00);

  cmd_state_e          state_q, state_d;
  cmd_op_e             cmd_op_q, cmd_op_d;
  logic [7:0]          cmd_val_q, cmd_val_d;
  logic                err_set;
  logic                dma_en_q, dma_en_d;
  logic [2:0]          task_max_q, task_max_d;
  logic [7:0]          val_q, val_d;
  logic                err_q, err_d;
  logic [CH_NUM-1:0]   irq_en_q, irq_en_d;
  logic                irq_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         ctrl_rd;

  logic [ADDR_W-1:0]   tbl    [CH_NUM];
  logic [TRIG_W-1:0]   trig   [CH_NUM];
  logic [CH_NUM-1:0]   status;
`ifdef PSRAM_CSR_IRQ_CNT_EN
  logic [7:0]          cnt    [CH_NUM];
`endif

  // Command slot: an op write is accepted only when the slot is empty; the accept cycle still counts as busy.
  always_comb begin
    state_d   = state_q;
    cmd_op_d  = cmd_op_q;
    cmd_val_d = cmd_val_q;
    err_set   = 1'b0;
    case (state_q)
      CMD_IDLE: begin
        if (op_wr) begin
          state_d   = CMD_PEND;
          cmd_op_d  = cmd_op_e'(ahb_bus_wdata[CTRL_OP_LSB +: 2]);
          cmd_val_d = ahb_bus_bsel[1] ? ahb_bus_wdata[CTRL_VAL_LSB +: 8] : val_q;
        end
      end
      CMD_PEND: begin
        if (cmd_ready) state_d = CMD_IDLE;
        if (op_wr)     err_set = 1'b1;
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  always_comb begin
    ctrl_rd                         = '0;
    ctrl_rd[CTRL_ERR_BIT]           = err_q;
    ctrl_rd[CTRL_TMAX_LSB +: 3]     = task_max_q;
    ctrl_rd[CTRL_EN_BIT]            = dma_en_q;
    ctrl_rd[CTRL_VAL_LSB +: 8]      = val_q;
    ctrl_rd[7:0]                    = task_list;
  end

  always_comb begin
    dma_en_d   = dma_en_q;
    task_max_d = task_max_q;
    val_d      = val_q;
    err_d      = err_q;
    irq_en_d   = irq_en_q;
    if (ctrl_wr && ahb_bus_bsel[2]) begin
      dma_en_d   = ahb_bus_wdata[CTRL_EN_BIT];
      task_max_d = ahb_bus_wdata[CTRL_TMAX_LSB +: 3];
      if (ahb_bus_wdata[CTRL_ERR_BIT]) err_d = 1'b0;
    end
    if (ctrl_wr && ahb_bus_bsel[1]) val_d = ahb_bus_wdata[CTRL_VAL_LSB +: 8];
    if (err_set) err_d = 1'b1;
    if (wen && ahb_bus_addr == BA_W'(REG_IRQ_EN)) begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (ahb_bus_bsel[i/8]) irq_en_d[i] = ahb_bus_wdata[i];
      end
    end
  end

  // Read mux works from the current register values, so a same-cycle write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = '0;
      if (ahb_bus_addr == BA_W'(REG_CTRL))       rdata_d = ctrl_rd;
      if (ahb_bus_addr == BA_W'(REG_IRQ_EN))     rdata_d[CH_NUM-1:0] = irq_en_q;
      if (ahb_bus_addr == BA_W'(REG_IRQ_STATUS)) rdata_d[CH_NUM-1:0] = status;
      if (ahb_bus_addr == BA_W'(REG_IRQ_PEND))   rdata_d[CH_NUM-1:0] = status & irq_en_q;
      for (int i = 0; i < CH_NUM; i++) begin
        if (ahb_bus_addr == BA_W'(REG_CH_BASE + 2*i))     rdata_d[ADDR_W-1:0] = tbl[i];
        if (ahb_bus_addr == BA_W'(REG_CH_BASE + 2*i + 1)) rdata_d[TRIG_W-1:0] = trig[i];
`ifdef PSRAM_CSR_IRQ_CNT_EN
        if (ahb_bus_addr == BA_W'(REG_CH_BASE + 2*CH_NUM + i)) rdata_d[7:0] = cnt[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= CMD_IDLE;
      cmd_op_q   <= OP_NONE;
      cmd_val_q  <= '0;
      dma_en_q   <= 1'b0;
      task_max_q <= '0;
      val_q      <= '0;
      err_q      <= 1'b0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      cmd_val_q  <= cmd_val_d;
      dma_en_q   <= dma_en_d;
      task_max_q <= task_max_d;
      val_q      <= val_d;
      err_q      <= err_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(status & irq_en_q);
      rdata_q    <= rdata_d;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    psram_dma_ch_csr #(
      .ADDR_W (ADDR_W),
      .TRIG_W (TRIG_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .tbl_we_i  (wen && ahb_bus_addr == BA_W'(REG_CH_BASE + 2*g)),
      .trig_we_i (wen && ahb_bus_addr == BA_W'(REG_CH_BASE + 2*g + 1)),
      .bsel_i    (ahb_bus_bsel),
      .wdata_i   (ahb_bus_wdata),
      .st_clr_i  (wen && ahb_bus_addr == BA_W'(REG_IRQ_STATUS) &&
                  ahb_bus_bsel[g/8] && ahb_bus_wdata[g]),
      .irq_set_i (irq_set[g]),
`ifdef PSRAM_CSR_IRQ_CNT_EN
      .cnt_rd_i  (ren && ahb_bus_addr == BA_W'(REG_CH_BASE + 2*CH_NUM + g)),
      .cnt_o     (cnt[g]),
`endif
      .tbl_o     (tbl[g]),
      .trig_o    (trig[g]),
      .status_o  (status[g])
    );
    assign table_addr[g*ADDR_W +: ADDR_W] = tbl[g];
    assign trig_mask[g*TRIG_W +: TRIG_W]  = trig[g];
  end

  assign ahb_bus_rdata = rdata_q;
  assign dma_en        = dma_en_q;
  assign task_max      = task_max_q;
  assign cmd_valid     = (state_q == CMD_PEND);
  assign cmd_op        = cmd_op_q;
  assign cmd_val       = cmd_val_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_psram_dma_csr.sv
// Directed testbench for psram_dma_csr (CH_NUM=4): register vector table plus command,
// IRQ, read/write-collision, reset and (with PSRAM_CSR_IRQ_CNT_EN) counter sequences.
module tb_psram_dma_csr;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         ahb_bus_sel = 1'b0;
  logic         ahb_bus_wr = 1'b0;
  logic         ahb_bus_rd = 1'b0;
  logic [4:0]   ahb_bus_addr = '0;
  logic [3:0]   ahb_bus_bsel = '0;
  logic [31:0]  ahb_bus_wdata = '0;
  logic [31:0]  ahb_bus_rdata;
  logic         dma_en;
  logic [2:0]   task_max;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_val;
  logic         cmd_ready = 1'b0;
  logic [7:0]   task_list = '0;
  logic [67:0]  table_addr;
  logic [127:0] trig_mask;
  logic [3:0]   irq_set = '0;
  logic         irq;

  int checks = 0;
  int failures = 0;

  psram_dma_csr #(.CH_NUM(4), .ADDR_W(17), .TRIG_W(32), .BA_W(5)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ahb_bus_sel   (ahb_bus_sel),
    .ahb_bus_wr    (ahb_bus_wr),
    .ahb_bus_rd    (ahb_bus_rd),
    .ahb_bus_addr  (ahb_bus_addr),
    .ahb_bus_bsel  (ahb_bus_bsel),
    .ahb_bus_wdata (ahb_bus_wdata),
    .ahb_bus_rdata (ahb_bus_rdata),
    .dma_en        (dma_en),
    .task_max      (task_max),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_val       (cmd_val),
    .cmd_ready     (cmd_ready),
    .task_list     (task_list),
    .table_addr    (table_addr),
    .trig_mask     (trig_mask),
    .irq_set       (irq_set),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [3:0]  bsel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    ahb_bus_sel = 1'b1; ahb_bus_wr = 1'b1; ahb_bus_addr = a; ahb_bus_bsel = be; ahb_bus_wdata = d;
    @(posedge clk); #1;
    ahb_bus_sel = 1'b0; ahb_bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    ahb_bus_sel = 1'b1; ahb_bus_rd = 1'b1; ahb_bus_addr = a;
    @(posedge clk); #1;
    d = ahb_bus_rdata;
    ahb_bus_sel = 1'b0; ahb_bus_rd = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0] = '{addr: 5'd6,  bsel: 4'b0100, wdata: 32'h0001_FFFF, exp: 32'h0001_2345};
    vecs[1] = '{addr: 5'd4,  bsel: 4'b1111, wdata: 32'hFFFF_FFFF, exp: 32'h0001_FFFF};
    vecs[2] = '{addr: 5'd5,  bsel: 4'b1010, wdata: 32'hAABB_CCDD, exp: 32'hAA00_CC00};
    vecs[3] = '{addr: 5'd11, bsel: 4'b1111, wdata: 32'h1234_5678, exp: 32'h1234_5678};
    vecs[4] = '{addr: 5'd1,  bsel: 4'b0001, wdata: 32'hFFFF_FFFF, exp: 32'h0000_000F};
    vecs[5] = '{addr: 5'd3,  bsel: 4'b1111, wdata: 32'hFFFF_FFFF, exp: 32'h0000_0000};
    vecs[6] = '{addr: 5'd31, bsel: 4'b1111, wdata: 32'hFFFF_FFFF, exp: 32'h0000_0000};
    vecs[7] = '{addr: 5'd0,  bsel: 4'b0100, wdata: 32'h0058_0000, exp: 32'h0058_00C3};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    #1;
    check("reset_rdata", ahb_bus_rdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    check("reset_cmd_valid", {31'd0, cmd_valid}, 32'h0);
    check("reset_dma_en", {31'd0, dma_en}, 32'h0);
    for (int a = 0; a < 16; a++) begin
      bus_read(5'(a), rd);
      check($sformatf("reset_read_a%0d", a), rd, 32'h0);
    end

    // Table ch1 lanes 0-1 only
    bus_write(5'd6, 4'b0011, 32'h0001_2345);
    bus_read(5'd6, rd);
    check("table1_read", rd, 32'h0000_2345);
    check("table1_slice", {15'd0, table_addr[33:17]}, 32'h0000_2345);
    @(posedge clk); #1;
    check("rdata_hold", ahb_bus_rdata, 32'h0000_2345);
    bus_read(5'd20, rd);
    check("unmapped_read", rd, 32'h0);

    // Register vector table
    task_list = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      bus_write(vecs[i].addr, vecs[i].bsel, vecs[i].wdata);
      bus_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_a%0d", i, vecs[i].addr), rd, vecs[i].exp);
    end
    check("dma_en_out", {31'd0, dma_en}, 32'h1);
    check("task_max_out", {29'd0, task_max}, 32'h5);
    check("table1_slice_final", {15'd0, table_addr[33:17]}, 32'h0001_2345);
    check("trig3_slice", trig_mask[127:96], 32'h1234_5678);

    // Command slot: load, dropped second op, accept
    bus_write(5'd0, 4'b0110, 32'h0001_5A00);
    check("cmd_valid_set", {31'd0, cmd_valid}, 32'h1);
    check("cmd_op_load", {30'd0, cmd_op}, 32'h1);
    check("cmd_val_load", {24'd0, cmd_val}, 32'h5A);
    bus_write(5'd0, 4'b0110, 32'h0003_7700);
    check("cmd_op_stable", {30'd0, cmd_op}, 32'h1);
    check("cmd_val_stable", {24'd0, cmd_val}, 32'h5A);
    check("cmd_valid_hold", {31'd0, cmd_valid}, 32'h1);
    bus_read(5'd0, rd);
    check("err_set", {31'd0, rd[23]}, 32'h1);
    check("op_reads_zero", {30'd0, rd[17:16]}, 32'h0);
    @(negedge clk); cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("cmd_accept", {31'd0, cmd_valid}, 32'h0);
    cmd_ready = 1'b0;
    bus_write(5'd0, 4'b0100, 32'h0080_0000);
    bus_read(5'd0, rd);
    check("err_clear", {31'd0, rd[23]}, 32'h0);

    // Op write on the accept cycle is dropped
    bus_write(5'd0, 4'b0110, 32'h0002_1100);
    check("cmd2_op", {30'd0, cmd_op}, 32'h2);
    @(negedge clk);
    ahb_bus_sel = 1'b1; ahb_bus_wr = 1'b1; ahb_bus_addr = 5'd0;
    ahb_bus_bsel = 4'b0100; ahb_bus_wdata = 32'h0003_0000; cmd_ready = 1'b1;
    @(posedge clk); #1;
    ahb_bus_sel = 1'b0; ahb_bus_wr = 1'b0; cmd_ready = 1'b0;
    check("accept_cycle_valid", {31'd0, cmd_valid}, 32'h0);
    check("accept_cycle_op", {30'd0, cmd_op}, 32'h2);
    bus_read(5'd0, rd);
    check("accept_cycle_err", {31'd0, rd[23]}, 32'h1);
    bus_write(5'd0, 4'b0100, 32'h0003_0000);
    check("cmd3_op", {30'd0, cmd_op}, 32'h3);
    check("cmd3_held_val", {24'd0, cmd_val}, 32'h11);

    // Asynchronous reset while a command is pending
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, cmd_valid}, 32'h0);
    check("async_rst_op", {30'd0, cmd_op}, 32'h0);
    check("async_rst_table", {15'd0, table_addr[33:17]}, 32'h0);
    @(negedge clk); rstn = 1'b1;

    // IRQ status / pend / W1C
    bus_write(5'd1, 4'b0001, 32'h0000_0005);
    @(negedge clk); irq_set = 4'b0111;
    @(posedge clk); #1; irq_set = 4'b0000;
    bus_read(5'd2, rd);
    check("irq_status", rd, 32'h7);
    check("irq_asserted", {31'd0, irq}, 32'h1);
    bus_read(5'd3, rd);
    check("irq_pend", rd, 32'h5);
    @(negedge clk);
    ahb_bus_sel = 1'b1; ahb_bus_wr = 1'b1; ahb_bus_addr = 5'd2;
    ahb_bus_bsel = 4'b0001; ahb_bus_wdata = 32'h1; irq_set = 4'b0001;
    @(posedge clk); #1;
    ahb_bus_sel = 1'b0; ahb_bus_wr = 1'b0; irq_set = 4'b0000;
    bus_read(5'd2, rd);
    check("set_wins", rd, 32'h7);
    bus_write(5'd2, 4'b0010, 32'h0000_0007);
    bus_read(5'd2, rd);
    check("w1c_lane_off", rd, 32'h7);
    bus_write(5'd2, 4'b0001, 32'h0000_0007);
    check("irq_lag", {31'd0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_cleared", {31'd0, irq}, 32'h0);
    bus_read(5'd2, rd);
    check("status_cleared", rd, 32'h0);

    // Same-cycle read and write of TRIG ch2
    bus_write(5'd9, 4'b1111, 32'h0BAD_F00D);
    @(negedge clk);
    ahb_bus_sel = 1'b1; ahb_bus_wr = 1'b1; ahb_bus_rd = 1'b1; ahb_bus_addr = 5'd9;
    ahb_bus_bsel = 4'b1111; ahb_bus_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rd = ahb_bus_rdata;
    ahb_bus_sel = 1'b0; ahb_bus_wr = 1'b0; ahb_bus_rd = 1'b0;
    check("rw_old_value", rd, 32'h0BAD_F00D);
    bus_read(5'd9, rd);
    check("rw_new_value", rd, 32'hFFFF_FFFF);

`ifdef PSRAM_CSR_IRQ_CNT_EN
    // Saturating clear-on-read counter, ch3 at address 15
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); irq_set[3] = 1'b1;
      @(negedge clk); irq_set[3] = 1'b0;
    end
    bus_read(5'd15, rd);
    check("cnt_saturate", rd, 32'd255);
    @(negedge clk);
    ahb_bus_sel = 1'b1; ahb_bus_rd = 1'b1; ahb_bus_addr = 5'd15; irq_set[3] = 1'b1;
    @(posedge clk); #1;
    rd = ahb_bus_rdata;
    ahb_bus_sel = 1'b0; ahb_bus_rd = 1'b0; irq_set[3] = 1'b0;
    check("cnt_cleared", rd, 32'd0);
    bus_read(5'd15, rd);
    check("cnt_inc_on_read", rd, 32'd1);
`else
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); irq_set[3] = 1'b1;
      @(negedge clk); irq_set[3] = 1'b0;
    end
    for (int a = 12; a < 16; a++) begin
      bus_read(5'(a), rd);
      check($sformatf("no_cnt_a%0d", a), rd, 32'h0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
